// File: rtl/keypad_scanner.sv
// Key-matrix scanner: drives one column at a time, samples the synchronised rows and
// debounces every key with per-key scan counters, emitting press/release events.
module keypad_scanner #(
  parameter int COLS = 4,
  parameter int ROWS = 4,
  parameter int CN   = 8,
  parameter int DN   = 3,
  localparam int KW  = (COLS * ROWS > 1) ? $clog2(COLS * ROWS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  output logic [COLS-1:0] col_o,
  input  logic [ROWS-1:0] row_i,
  output logic            evt_vld,
  input  logic            evt_rdy,
  output logic [KW-1:0]   evt_key,
  output logic            evt_press,
  output logic            frame_o
);

  localparam int NK  = COLS * ROWS;
  localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SW  = $clog2(CN);
  localparam int CW  = (DN > 1) ? $clog2(DN) : 1;

  localparam logic [1:0] ST_SETTLE = 2'd0;
  localparam logic [1:0] ST_SAMPLE = 2'd1;
  localparam logic [1:0] ST_EVAL   = 2'd2;

  logic [1:0]      fsm;
  logic [CLW-1:0]  col;
  logic [RW-1:0]   row;
  logic [SW-1:0]   settle_cnt;
  logic [ROWS-1:0] row_p0;
  logic [ROWS-1:0] row_p1;
  logic [ROWS-1:0] snap;
  logic [NK-1:0]   key_state;
  logic [CW-1:0]   key_cnt [NK];

  logic [KW-1:0]   key_idx;
  logic            snap_bit;
  logic            cur_state;
  logic [CW-1:0]   cur_cnt;
  logic            in_eval;
  logic            differ;
  logic            flip;
  logic            out_free;
  logic            stall;
  logic            last_row;
  logic            last_col;

  function automatic logic [COLS-1:0] col_drive(input logic [CLW-1:0] c);
    col_drive = ~(COLS'(1) << c);
  endfunction

  assign col_o     = en ? col_drive(col) : '1;
  assign key_idx   = KW'(int'(col) * ROWS + int'(row));
  assign snap_bit  = snap[row];
  assign cur_state = key_state[key_idx];
  assign cur_cnt   = key_cnt[key_idx];
  assign in_eval   = en && (fsm == ST_EVAL);
  assign differ    = snap_bit != cur_state;
  assign flip      = in_eval && differ && (cur_cnt == CW'(DN - 1));
  // A flip that cannot be handed to the output register freezes the scan on this key.
  assign out_free  = !evt_vld || evt_rdy;
  assign stall     = flip && !out_free;
  assign last_row  = row == RW'(ROWS - 1);
  assign last_col  = col == CLW'(COLS - 1);

  // p0/p1: two-flop synchroniser on the asynchronous row inputs (idle = pulled high)
  always_ff @(posedge clk) begin
    if (rst) begin
      row_p0 <= '1;
      row_p1 <= '1;
    end else begin
      row_p0 <= row_i;
      row_p1 <= row_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      fsm        <= ST_SETTLE;
      col        <= '0;
      row        <= '0;
      settle_cnt <= '0;
    end else begin
      case (fsm)
        ST_SETTLE: begin
          if (settle_cnt == SW'(CN - 1)) begin
            settle_cnt <= '0;
            fsm        <= ST_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ST_SAMPLE: begin
          row <= '0;
          fsm <= ST_EVAL;
        end
        ST_EVAL: begin
          if (!stall) begin
            if (last_row) begin
              row <= '0;
              col <= last_col ? '0 : col + 1'b1;
              fsm <= ST_SETTLE;
            end else begin
              row <= row + 1'b1;
            end
          end
        end
        default: fsm <= ST_SETTLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap <= '0;
    end else if (en && fsm == ST_SAMPLE) begin
      snap <= ~row_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_state <= '0;
      for (int k = 0; k < NK; k++) key_cnt[k] <= '0;
    end else if (in_eval && !stall) begin
      if (!differ) begin
        key_cnt[key_idx] <= '0;
      end else if (cur_cnt == CW'(DN - 1)) begin
        key_state[key_idx] <= snap_bit;
        key_cnt[key_idx]   <= '0;
      end else begin
        key_cnt[key_idx] <= cur_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_vld   <= 1'b0;
      evt_key   <= '0;
      evt_press <= 1'b0;
      frame_o   <= 1'b0;
    end else begin
      frame_o <= in_eval && last_row && last_col && !stall;
      if (flip && out_free) begin
        evt_vld   <= 1'b1;
        evt_key   <= key_idx;
        evt_press <= snap_bit;
      end else if (evt_rdy) begin
        evt_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed scan/debounce/stall/reset/enable steps followed by
// random key patterns with random back-pressure, checked against an event-level model.
module tb_keypad_scanner;

  localparam int COLS  = 4;
  localparam int ROWS  = 4;
  localparam int CN    = 8;
  localparam int DN    = 3;
  localparam int KW    = 4;
  localparam int NK    = COLS * ROWS;
  localparam int COLT  = CN + 1 + ROWS;
  localparam int FRAME = COLS * COLT;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [COLS-1:0] col_o;
  logic [ROWS-1:0] row_i;
  logic            evt_vld;
  logic            evt_rdy;
  logic [KW-1:0]   evt_key;
  logic            evt_press;
  logic            frame_o;

  logic [NK-1:0]   keys;
  int              checks = 0;
  int              errors = 0;
  int              tick = 0;
  int              t_rel = 0;

  logic            hold_p = 1'b0;
  logic [KW-1:0]   hold_key = '0;
  logic            hold_press = 1'b0;
  logic [KW:0]     acc_q [$];

  always #5 clk = ~clk;

  keypad_scanner #(.COLS(COLS), .ROWS(ROWS), .CN(CN), .DN(DN)) dut (
    .clk(clk), .rst(rst), .en(en), .col_o(col_o), .row_i(row_i),
    .evt_vld(evt_vld), .evt_rdy(evt_rdy), .evt_key(evt_key),
    .evt_press(evt_press), .frame_o(frame_o)
  );

  // Physical matrix: a closed key pulls its row low only while its column is driven.
  always_comb begin
    row_i = '1;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (!col_o[c] && keys[c*ROWS + r]) row_i[r] = 1'b0;
  end

  always @(posedge clk) begin
    tick       <= tick + 1;
    hold_p     <= !rst && evt_vld && !evt_rdy;
    hold_key   <= evt_key;
    hold_press <= evt_press;
    if (!rst && evt_vld && evt_rdy) acc_q.push_back({evt_key, evt_press});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // An offered event must stay put until it is accepted.
  always @(negedge clk) begin
    if (hold_p) begin
      chk("hold_vld", evt_vld, 1);
      chk("hold_key", evt_key, hold_key);
      chk("hold_press", evt_press, hold_press);
    end
  end

  function automatic logic [COLS-1:0] onecold(input int c);
    logic [COLS-1:0] v;
    v = '1;
    v[c] = 1'b0;
    return v;
  endfunction

  // Edge (counted from scan restart) of the n-th evaluation of key (c,r) that sees a
  // level applied after edge k0; the sample must land at least two edges after the change.
  function automatic int eval_edge(input int k0, input int c, input int r, input int n);
    int f;
    f = 0;
    while (f + c*COLT + CN + 1 <= k0 + 2) f += FRAME;
    return f + c*COLT + CN + 2 + r + (n - 1) * FRAME;
  endfunction

  task automatic wait_evt(input int max, output bit got, output int t);
    got = 1'b0;
    t = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (evt_vld) begin
        got = 1'b1;
        t = tick - t_rel;
        break;
      end
    end
  endtask

  task automatic expect_evt(input string tag, input int e, input int key, input bit press);
    bit got;
    int t;
    wait_evt(6 * FRAME, got, t);
    chk({tag, "_got"}, got, 1);
    chk({tag, "_time"}, t, e);
    chk({tag, "_key"}, evt_key, key);
    chk({tag, "_press"}, evt_press, press);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit            got;
    int            t, e, k0, kk;
    logic [KW:0]   ev;
    logic [NK-1:0] pat, changed, seen, model_state;
    int            last_row [COLS];

    rst = 1'b1; en = 1'b1; evt_rdy = 1'b1; keys = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_col", col_o, onecold(0));
    chk("rst_vld", evt_vld, 0);
    chk("rst_key", evt_key, 0);
    chk("rst_press", evt_press, 0);
    chk("rst_frame", frame_o, 0);
    rst = 1'b0;
    t_rel = tick;

    // 1: idle scan timing
    for (int k = 1; k <= 2 * FRAME; k++) begin
      @(negedge clk);
      chk("t1_col", col_o, onecold((k / COLT) % COLS));
      chk("t1_frame", frame_o, (k % FRAME) == 0);
      chk("t1_vld", evt_vld, 0);
    end

    // 2: steady press and release of key 9
    keys[9] = 1'b1;
    e = eval_edge(tick - t_rel, 2, 1, DN);
    expect_evt("t2_press", e, 9, 1'b1);
    keys[9] = 1'b0;
    e = eval_edge(tick - t_rel, 2, 1, DN);
    expect_evt("t2_release", e, 9, 1'b0);

    // 3: closure seen by a single scan must not produce an event
    @(negedge clk);
    keys[9] = 1'b1;
    e = eval_edge(tick - t_rel, 2, 1, 1);
    while (tick - t_rel < e) @(negedge clk);
    keys[9] = 1'b0;
    wait_evt(3 * FRAME, got, t);
    chk("t3_noevt", got, 0);
    keys[9] = 1'b1;
    e = eval_edge(tick - t_rel, 2, 1, DN);
    expect_evt("t3_press", e, 9, 1'b1);
    keys[9] = 1'b0;
    e = eval_edge(tick - t_rel, 2, 1, DN);
    expect_evt("t3_release", e, 9, 1'b0);

    // 4: back-pressure stalls evaluation of key 6
    @(negedge clk);
    evt_rdy = 1'b0;
    keys[4] = 1'b1;
    keys[6] = 1'b1;
    e = eval_edge(tick - t_rel, 1, 0, DN);
    expect_evt("t4_k4", e, 4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_stall_vld", evt_vld, 1);
      chk("t4_stall_key", evt_key, 4);
      chk("t4_stall_col", col_o, onecold(1));
    end
    evt_rdy = 1'b1;
    @(negedge clk);
    chk("t4_k6_vld", evt_vld, 1);
    chk("t4_k6_key", evt_key, 6);
    chk("t4_k6_press", evt_press, 1);
    chk("t4_k6_col", col_o, onecold(1));
    @(negedge clk);
    chk("t4_resume_col", col_o, onecold(2));
    chk("t4_resume_vld", evt_vld, 0);
    t_rel += 3;

    // 5: reset during a stall
    evt_rdy = 1'b0;
    keys[4] = 1'b0;
    keys[6] = 1'b0;
    e = eval_edge(tick - t_rel, 1, 0, DN);
    expect_evt("t5_k4", e, 4, 1'b0);
    repeat (3) @(negedge clk);
    chk("t5_stall_key", evt_key, 4);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_vld", evt_vld, 0);
    chk("t5_rst_col", col_o, onecold(0));
    chk("t5_rst_key", evt_key, 0);
    chk("t5_rst_frame", frame_o, 0);
    rst = 1'b0;
    evt_rdy = 1'b1;
    t_rel = tick;
    keys[6] = 1'b1;
    e = eval_edge(0, 1, 2, DN);
    expect_evt("t5_k6", e, 6, 1'b1);

    // 6: scan disable mid column 2
    while (tick - t_rel < e + 6) @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t6_off_col", col_o, 4'hF);
      chk("t6_off_vld", evt_vld, 0);
      chk("t6_off_frame", frame_o, 0);
    end
    en = 1'b1;
    #1;
    chk("t6_on_col", col_o, onecold(0));
    t_rel = tick;
    keys[6] = 1'b0;
    repeat (COLT - 1) @(negedge clk);
    chk("t6_col0_hold", col_o, onecold(0));
    @(negedge clk);
    chk("t6_col1", col_o, onecold(1));
    e = eval_edge(0, 1, 2, DN);
    expect_evt("t6_k6", e, 6, 1'b0);

    // random key patterns under random back-pressure
    @(negedge clk);
    acc_q.delete();
    model_state = '0;
    for (int ep = 0; ep < 8; ep++) begin
      pat = (ep == 0) ? '1 : NK'($urandom);
      keys = pat;
      changed = pat ^ model_state;
      repeat (450) begin
        @(negedge clk);
        evt_rdy = ($urandom_range(0, 3) != 0);
      end
      evt_rdy = 1'b1;
      repeat (4) @(negedge clk);
      chk("rnd_count", acc_q.size(), $countones(changed));
      seen = '0;
      for (int c = 0; c < COLS; c++) last_row[c] = -1;
      while (acc_q.size() > 0) begin
        ev = acc_q.pop_front();
        kk = int'(ev[KW:1]);
        chk("rnd_changed", changed[kk], 1);
        chk("rnd_dup", seen[kk], 0);
        chk("rnd_press", ev[0], pat[kk]);
        chk("rnd_order", (kk % ROWS) > last_row[kk / ROWS], 1);
        last_row[kk / ROWS] = kk % ROWS;
        seen[kk] = 1'b1;
      end
      chk("rnd_all", seen, changed);
      model_state = pat;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
